// File: rtl/pad_stream_tx.sv
// Turns a raw IMG_W x STRIP_H pixel strip into the zero-padded (IMG_W+2) x (STRIP_H+2)
// raster so the 3x3 window buffer fills linearly from address 0 with one-pixel borders.
module pad_stream_tx #(
  parameter int DW      = 8,
  parameter int IMG_W   = 256,
  parameter int STRIP_H = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_pixel,
  output logic          in_ready,
  output logic          wr,
  output logic [DW-1:0] pixelw,
  output logic          busy,
  output logic          done
);

  localparam int COL_W = $clog2(IMG_W + 2);
  localparam int ROW_W = $clog2(STRIP_H + 2);

  localparam logic [COL_W-1:0] COL_PAD_LAST  = COL_W'(IMG_W + 1);
  localparam logic [COL_W-1:0] COL_DATA_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(STRIP_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOP,
    S_LEFT,
    S_DATA,
    S_RIGHT,
    S_BOT,
    S_FIN
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] w_col_nxt;
  logic [ROW_W-1:0] r_row;
  logic [ROW_W-1:0] w_row_nxt;
  logic             w_emit;
  logic             w_take;

  logic             r_wr_p1;
  logic [DW-1:0]    r_pixelw_p1;
  logic             r_done_p1;
  logic             r_busy_p1;

  // Pad states emit every cycle; only DATA can stall on in_valid.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_emit      = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_TOP;
        end
      end
      S_TOP, S_BOT: begin
        w_emit = 1'b1;
        if (r_col == COL_PAD_LAST) begin
          w_col_nxt   = '0;
          w_state_nxt = (r_state == S_TOP) ? S_LEFT : S_FIN;
        end else begin
          w_col_nxt = r_col + COL_W'(1);
        end
      end
      S_LEFT: begin
        w_emit      = 1'b1;
        w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (in_valid) begin
          w_emit = 1'b1;
          w_take = 1'b1;
          if (r_col == COL_DATA_LAST) begin
            w_col_nxt   = '0;
            w_state_nxt = S_RIGHT;
          end else begin
            w_col_nxt = r_col + COL_W'(1);
          end
        end
      end
      S_RIGHT: begin
        w_emit = 1'b1;
        if (r_row == ROW_LAST) begin
          w_row_nxt   = '0;
          w_state_nxt = S_BOT;
        end else begin
          w_row_nxt   = r_row + ROW_W'(1);
          w_state_nxt = S_LEFT;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign in_ready = (r_state == S_DATA);

  // Stage p1: registered write strobe, data and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_wr_p1     <= 1'b0;
      r_pixelw_p1 <= '0;
      r_done_p1   <= 1'b0;
      r_busy_p1   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_wr_p1     <= w_emit;
      r_pixelw_p1 <= w_take ? in_pixel : '0;
      r_done_p1   <= (r_state == S_FIN);
      r_busy_p1   <= (w_state_nxt != S_IDLE);
    end
  end

  assign wr     = r_wr_p1;
  assign pixelw = r_pixelw_p1;
  assign done   = r_done_p1;
  assign busy   = r_busy_p1;

endmodule

// File: tb/tb_pad_stream_tx.sv
// Directed bench for pad_stream_tx: default 256x32 strip and a small 4x2 override instance.
module tb_pad_stream_tx;

  localparam int W   = 256;
  localparam int H   = 32;
  localparam int PW  = W + 2;
  localparam int NWR = PW * (H + 2);
  localparam int CAP = NWR + 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, in_valid, in_ready, wr, busy, done;
  logic [7:0] in_pixel, pixelw;

  logic       s_start, s_in_valid, s_in_ready, s_wr, s_busy, s_done;
  logic [7:0] s_in_pixel, s_pixelw;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] cap [0:CAP-1];
  int n_wr, n_hs, n_rdy, cyc, wr_rise, busy_rise, done_cyc, last_wr, busy_at_done;

  int exp_s [0:23] = '{0, 0, 0, 0, 0, 0,
                       0, 1, 2, 3, 4, 0,
                       0, 5, 6, 7, 8, 0,
                       0, 0, 0, 0, 0, 0};

  pad_stream_tx #(.DW(8), .IMG_W(W), .STRIP_H(H)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_ready(in_ready), .wr(wr), .pixelw(pixelw), .busy(busy), .done(done)
  );

  pad_stream_tx #(.DW(8), .IMG_W(4), .STRIP_H(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_pixel(s_in_pixel),
    .in_ready(s_in_ready), .wr(s_wr), .pixelw(s_pixelw), .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Padded raster value for write index i when raw pixel n carries n mod 256.
  function automatic logic [7:0] exp_pix(input int i);
    int r, c;
    r = i / PW;
    c = i % PW;
    if (r == 0 || r == H + 1 || c == 0 || c == PW - 1) return 8'd0;
    return 8'(((r - 1) * W + (c - 1)) % 256);
  endfunction

  function automatic int seq_errs(input int n);
    int e = 0;
    for (int i = 0; i < n && i < CAP; i++) begin
      if (cap[i] != exp_pix(i)) e++;
    end
    return e;
  endfunction

  // Entered just after a rising edge; the cycle with start high is cycle 0.
  task automatic run_strip(input bit rnd, input int abort_at, input bit restart_mid);
    n_wr = 0; n_hs = 0; n_rdy = 0; cyc = 0;
    wr_rise = -1; busy_rise = -1; done_cyc = -1; last_wr = -1; busy_at_done = -1;
    start = 1'b1;
    in_valid = 1'b1;
    in_pixel = 8'd0;
    chk("idle_in_ready", in_ready, 0);
    while (done_cyc < 0 && cyc < 40000) begin
      @(posedge clk);
      #1;
      cyc++;
      start = restart_mid && (cyc == 300);
      if (wr) begin
        if (n_wr < CAP) cap[n_wr] = pixelw;
        if (wr_rise < 0) wr_rise = cyc;
        last_wr = cyc;
        n_wr++;
      end
      if (busy && busy_rise < 0) busy_rise = cyc;
      if (done) begin
        done_cyc = cyc;
        busy_at_done = busy;
      end
      if (abort_at > 0 && n_wr == abort_at) begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_wr", wr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        rst = 1'b0;
        return;
      end
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_pixel = 8'(n_hs);
      if (in_ready) n_rdy++;
      if (in_ready && in_valid) n_hs++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("strip_timeout", (done_cyc >= 0), 1);
  endtask

  task automatic run_small();
    int sw, shs, sc, sdone, slast, early_rdy, first_rdy, errs;
    logic [7:0] scap [0:31];
    sw = 0; shs = 0; sc = 0; sdone = -1; slast = -1; early_rdy = 0; first_rdy = -1;
    s_start = 1'b1;
    s_in_valid = 1'b1;
    s_in_pixel = 8'd1;
    if (s_in_ready) early_rdy++;
    while (sdone < 0 && sc < 200) begin
      @(posedge clk);
      #1;
      sc++;
      s_start = 1'b0;
      if (s_wr) begin
        if (sw < 32) scap[sw] = s_pixelw;
        slast = sc;
        sw++;
      end
      if (s_done) sdone = sc;
      if (s_in_ready && first_rdy < 0) first_rdy = sc;
      if (s_in_ready && sc < 8) early_rdy++;
      s_in_valid = 1'b1;
      s_in_pixel = 8'(shs + 1);
      if (s_in_ready && s_in_valid) shs++;
    end
    s_in_valid = 1'b0;
    chk("small_timeout", (sdone >= 0), 1);
    chk("small_n_wr", sw, 24);
    errs = 0;
    for (int i = 0; i < 24 && i < sw; i++) begin
      if (int'(scap[i]) != exp_s[i]) errs++;
    end
    chk("small_seq_errs", errs, 0);
    chk("small_w7", scap[7], 1);
    chk("small_w16", scap[16], 8);
    chk("small_early_ready", early_rdy, 0);
    chk("small_first_ready", first_rdy, 8);
    chk("small_n_hs", shs, 8);
    chk("small_done_lat", sdone - slast, 1);
  endtask

  initial begin
    int tail_nz;
    rst = 1'b1;
    start = 1'b0; in_valid = 1'b0; in_pixel = 8'd0;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_pixel = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr", wr, 0);
    chk("rst_pixelw", pixelw, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_small();

    // Full-rate strip with a second start pulse mid-strip.
    run_strip(1'b0, 0, 1'b1);
    chk("full_n_wr", n_wr, NWR);
    chk("full_seq_errs", seq_errs(n_wr), 0);
    chk("full_w258", cap[258], 0);
    chk("full_w259", cap[259], 0);
    chk("full_w514", cap[514], 255);
    chk("full_w515", cap[515], 0);
    tail_nz = 0;
    for (int i = NWR - PW; i < NWR; i++) if (cap[i] != 8'd0) tail_nz++;
    chk("full_tail_nonzero", tail_nz, 0);
    chk("full_wr_rise", wr_rise, 2);
    chk("full_busy_rise", busy_rise, 1);
    chk("full_done_lat", done_cyc - last_wr, 1);
    chk("full_busy_at_done", busy_at_done, 0);
    chk("full_n_hs", n_hs, W * H);
    chk("full_ready_cycles", n_rdy, W * H);

    // Random 50% in_valid.
    run_strip(1'b1, 0, 1'b0);
    chk("rnd_n_wr", n_wr, NWR);
    chk("rnd_seq_errs", seq_errs(n_wr), 0);
    chk("rnd_n_hs", n_hs, W * H);
    chk("rnd_done_lat", done_cyc - last_wr, 1);

    // Abort after 4000 writes, then a clean strip.
    run_strip(1'b0, 4000, 1'b0);
    @(posedge clk);
    #1;
    run_strip(1'b0, 0, 1'b0);
    chk("post_abort_n_wr", n_wr, NWR);
    chk("post_abort_seq_errs", seq_errs(n_wr), 0);
    chk("post_abort_wr_rise", wr_rise, 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
